egg_timer_ctrl: RTL and testbench

//  Sequencing controller for the egg-timer board. Conditions the three push keys,

---
 rtl/egg_timer_ctrl.sv | 245 ++++++++++++++++++++++++
 tb/tb_egg_timer_ctrl.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/egg_timer_ctrl.sv
// egg_timer_ctrl
//   Sequencing controller for the egg-timer board. Conditions the three
//   push keys, holds the mm:ss BCD time and steps the state sequence
//   RESET -> SET_SEC -> SET_MIN -> READY -> TIMER -> FLASH_ON/FLASH_OFF.
//
// Ports
//   CLOCK_50  in   system clock, rising edge
//   RESET_N   in   asynchronous active-low reset
//   KEY[2:0]  in   active-low keys: [0]=SET, [1]=START/PAUSE, [2]=CLEAR
//   SW[7:0]   in   BCD entry value, [7:4]=tens, [3:0]=ones
//   state     out  current state, {1'b0, enc[2:0]}
//   min_bcd   out  minutes, two BCD digits
//   sec_bcd   out  seconds, two BCD digits
//   running   out  high while in TIMER
//   alarm_on  out  high while in FLASH_ON
module egg_timer_ctrl #(
    parameter int unsigned TICK_DIV  = 50_000_000,
    parameter int unsigned FLASH_DIV = 12_500_000,
    parameter int unsigned DB_CYCLES = 500_000
) (
    input  logic       CLOCK_50,
    input  logic       RESET_N,
    input  logic [2:0] KEY,
    input  logic [7:0] SW,
    output logic [3:0] state,
    output logic [7:0] min_bcd,
    output logic [7:0] sec_bcd,
    output logic       running,
    output logic       alarm_on
);

    localparam int unsigned TICK_W  = (TICK_DIV  > 1) ? $clog2(TICK_DIV)  : 1;
    localparam int unsigned FLASH_W = (FLASH_DIV > 1) ? $clog2(FLASH_DIV) : 1;
    localparam int unsigned DB_W    = $clog2(DB_CYCLES + 1);

    localparam logic [TICK_W-1:0]  TICK_LAST  = TICK_W'(TICK_DIV - 1);
    localparam logic [FLASH_W-1:0] FLASH_LAST = FLASH_W'(FLASH_DIV - 1);
    localparam logic [DB_W-1:0]    DB_FIRE    = DB_W'(DB_CYCLES - 1);
    localparam logic [DB_W-1:0]    DB_MAX     = DB_W'(DB_CYCLES);

    localparam logic [2:0] S_SET_SEC   = 3'd0;
    localparam logic [2:0] S_SET_MIN   = 3'd1;
    localparam logic [2:0] S_TIMER     = 3'd2;
    localparam logic [2:0] S_READY     = 3'd3;
    localparam logic [2:0] S_RESET     = 3'd4;
    localparam logic [2:0] S_FLASH_ON  = 3'd5;
    localparam logic [2:0] S_FLASH_OFF = 3'd6;

    // ------------------------------------------------------------------
    // Key conditioning
    // ------------------------------------------------------------------
    logic [2:0]      key_meta;
    logic [2:0]      key_sync;
    logic [DB_W-1:0] db_cnt [3];
    logic [2:0]      key_ev;

    // The counter saturates at DB_CYCLES so a held key yields exactly one
    // event; it only rearms once the synchronised key reads released.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            key_meta <= '1;
            key_sync <= '1;
            for (int unsigned i = 0; i < 3; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            key_meta <= KEY;
            key_sync <= key_meta;
            for (int unsigned i = 0; i < 3; i++) begin
                if (key_sync[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] != DB_MAX) begin
                    db_cnt[i] <= db_cnt[i] + DB_W'(1);
                end
            end
        end
    end

    // Event fires in the DB_CYCLES-th consecutive low cycle.
    always_comb begin
        for (int unsigned i = 0; i < 3; i++) begin
            key_ev[i] = !key_sync[i] && (db_cnt[i] == DB_FIRE);
        end
    end

    logic set_ev, start_ev, clr_ev;
    assign set_ev   = key_ev[0];
    assign start_ev = key_ev[1];
    assign clr_ev   = key_ev[2];

    // ------------------------------------------------------------------
    // State, time and prescalers
    // ------------------------------------------------------------------
    logic [2:0]         st_q, st_d;
    logic [7:0]         min_q, min_d;
    logic [7:0]         sec_q, sec_d;
    logic [TICK_W-1:0]  tick_q, tick_d;
    logic [FLASH_W-1:0] flash_q, flash_d;

    logic       tick;
    logic       time_zero;
    logic       sw_sec_ok, sw_min_ok;
    logic [7:0] sec_dec, min_dec;
    logic       sec_borrow;
    logic [7:0] min_nxt, sec_nxt;

    assign tick      = (tick_q == TICK_LAST);
    assign time_zero = (min_q == 8'h00) && (sec_q == 8'h00);
    assign sw_sec_ok = (SW[7:4] <= 4'd5) && (SW[3:0] <= 4'd9);
    assign sw_min_ok = (SW[7:4] <= 4'd9) && (SW[3:0] <= 4'd9);

    // BCD countdown; seconds wrap 00 -> 59 and borrow from the minutes.
    always_comb begin
        sec_borrow = 1'b0;
        if (sec_q[3:0] != 4'd0) begin
            sec_dec = {sec_q[7:4], sec_q[3:0] - 4'd1};
        end else if (sec_q[7:4] != 4'd0) begin
            sec_dec = {sec_q[7:4] - 4'd1, 4'd9};
        end else begin
            sec_dec    = 8'h59;
            sec_borrow = 1'b1;
        end

        if (min_q[3:0] != 4'd0) begin
            min_dec = {min_q[7:4], min_q[3:0] - 4'd1};
        end else if (min_q[7:4] != 4'd0) begin
            min_dec = {min_q[7:4] - 4'd1, 4'd9};
        end else begin
            min_dec = 8'h99;
        end

        sec_nxt = sec_dec;
        min_nxt = sec_borrow ? min_dec : min_q;
    end

    always_comb begin
        st_d    = st_q;
        min_d   = min_q;
        sec_d   = sec_q;
        tick_d  = tick_q;
        flash_d = flash_q;

        if (clr_ev) begin
            st_d = S_RESET;
        end else begin
            case (st_q)
                S_RESET: begin
                    min_d   = '0;
                    sec_d   = '0;
                    tick_d  = '0;
                    flash_d = '0;
                    st_d    = S_SET_SEC;
                end
                S_SET_SEC: begin
                    if (sw_sec_ok) begin
                        sec_d = SW;
                    end
                    if (set_ev) begin
                        st_d = S_SET_MIN;
                    end
                end
                S_SET_MIN: begin
                    if (sw_min_ok) begin
                        min_d = SW;
                    end
                    if (set_ev) begin
                        st_d = S_READY;
                    end
                end
                S_READY: begin
                    if (set_ev) begin
                        st_d = S_SET_SEC;
                    end else if (start_ev) begin
                        if (time_zero) begin
                            st_d    = S_FLASH_ON;
                            flash_d = '0;
                        end else begin
                            st_d   = S_TIMER;
                            tick_d = '0;
                        end
                    end
                end
                S_TIMER: begin
                    // Pause wins over a coincident tick, which is dropped.
                    if (start_ev) begin
                        st_d = S_READY;
                    end else if (tick) begin
                        tick_d = '0;
                        min_d  = min_nxt;
                        sec_d  = sec_nxt;
                        if ((min_nxt == 8'h00) && (sec_nxt == 8'h00)) begin
                            st_d    = S_FLASH_ON;
                            flash_d = '0;
                        end
                    end else begin
                        tick_d = tick_q + TICK_W'(1);
                    end
                end
                S_FLASH_ON, S_FLASH_OFF: begin
                    if (set_ev || start_ev) begin
                        st_d = S_RESET;
                    end else if (flash_q == FLASH_LAST) begin
                        flash_d = '0;
                        st_d    = (st_q == S_FLASH_ON) ? S_FLASH_OFF : S_FLASH_ON;
                    end else begin
                        flash_d = flash_q + FLASH_W'(1);
                    end
                end
                default: begin
                    st_d = S_RESET;
                end
            endcase
        end
    end

    logic running_q, alarm_q;

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            st_q      <= S_RESET;
            min_q     <= '0;
            sec_q     <= '0;
            tick_q    <= '0;
            flash_q   <= '0;
            running_q <= 1'b0;
            alarm_q   <= 1'b0;
        end else begin
            st_q      <= st_d;
            min_q     <= min_d;
            sec_q     <= sec_d;
            tick_q    <= tick_d;
            flash_q   <= flash_d;
            // Flag flops track the state register exactly.
            running_q <= (st_d == S_TIMER);
            alarm_q   <= (st_d == S_FLASH_ON);
        end
    end

    assign state    = {1'b0, st_q};
    assign min_bcd  = min_q;
    assign sec_bcd  = sec_q;
    assign running  = running_q;
    assign alarm_on = alarm_q;

endmodule

// File: tb/tb_egg_timer_ctrl.sv
// tb_egg_timer_ctrl
//   Self-checking bench for egg_timer_ctrl with short dividers
//   (TICK_DIV=10, FLASH_DIV=4, DB_CYCLES=2). Expected observations are
//   queued when stimulus is applied and compared when sampled.
module tb_egg_timer_ctrl;

    logic       clk;
    logic       rst_n;
    logic [2:0] key;
    logic [7:0] sw;
    logic [3:0] state;
    logic [7:0] min_bcd;
    logic [7:0] sec_bcd;
    logic       running;
    logic       alarm_on;

    int unsigned checks   = 0;
    int unsigned failures = 0;

    egg_timer_ctrl #(
        .TICK_DIV (10),
        .FLASH_DIV(4),
        .DB_CYCLES(2)
    ) dut (
        .CLOCK_50(clk),
        .RESET_N (rst_n),
        .KEY     (key),
        .SW      (sw),
        .state   (state),
        .min_bcd (min_bcd),
        .sec_bcd (sec_bcd),
        .running (running),
        .alarm_on(alarm_on)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [21:0] M_ALL   = '1;
    localparam logic [21:0] M_STATE = {4'hF, 18'h0};

    typedef struct {
        string       tag;
        logic [21:0] exp;
        logic [21:0] mask;
    } exp_t;

    exp_t sb_q[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    // Observation = {state, min, sec, running, alarm_on}.
    task automatic sb_push(input string tag, input logic [3:0] st, input logic [7:0] mn,
                           input logic [7:0] sc, input logic [21:0] mask);
        exp_t e;
        e.tag  = tag;
        e.exp  = {st, mn, sc, (st == 4'd2), (st == 4'd5)};
        e.mask = mask;
        sb_q.push_back(e);
    endtask

    task automatic sb_sample();
        exp_t        e;
        logic [21:0] obs;
        if (sb_q.size() == 0) begin
            check_eq("sb_underflow", 32'd1, 32'd0);
        end else begin
            e   = sb_q.pop_front();
            obs = {state, min_bcd, sec_bcd, running, alarm_on};
            check_eq(e.tag, {10'd0, obs & e.mask}, {10'd0, e.exp & e.mask});
        end
    endtask

    task automatic idle(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Press takes effect on the fourth edge after the key is driven low
    // (two synchroniser flops plus two debounce cycles); returns just after it.
    task automatic press(input logic [2:0] mask);
        @(posedge clk);
        #1 key = ~mask;
        repeat (4) @(posedge clk);
        #1 key = 3'b111;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        key   = 3'b111;
        sw    = 8'h00;

        // Reset
        repeat (3) @(posedge clk);
        #1;
        sb_push("rst_state", 4'd4, 8'h00, 8'h00, M_ALL);
        sb_sample();
        rst_n = 1'b1;
        sb_push("rst_release_hold", 4'd4, 8'h00, 8'h00, M_ALL);
        sb_sample();
        sb_push("to_set_sec", 4'd0, 8'h00, 8'h00, M_ALL);
        idle(1);
        sb_sample();

        // Seconds entry with validity checks
        sb_push("sec_59", 4'd0, 8'h00, 8'h59, M_ALL);
        sw = 8'h59; idle(1); sb_sample();
        sb_push("sec_7A_rej", 4'd0, 8'h00, 8'h59, M_ALL);
        sw = 8'h7A; idle(2); sb_sample();
        sb_push("sec_5A_rej", 4'd0, 8'h00, 8'h59, M_ALL);
        sw = 8'h5A; idle(1); sb_sample();
        sb_push("sec_60_rej", 4'd0, 8'h00, 8'h59, M_ALL);
        sw = 8'h60; idle(1); sb_sample();
        sb_push("sec_25", 4'd0, 8'h00, 8'h25, M_ALL);
        sw = 8'h25; idle(1); sb_sample();

        sb_push("set_to_min", 4'd1, 8'h00, 8'h25, M_ALL);
        press(3'b001); sb_sample();

        // Minutes entry
        sb_push("min_99", 4'd1, 8'h99, 8'h25, M_ALL);
        sw = 8'h99; idle(1); sb_sample();
        sb_push("min_A0_rej", 4'd1, 8'h99, 8'h25, M_ALL);
        sw = 8'hA0; idle(2); sb_sample();
        sb_push("min_01", 4'd1, 8'h01, 8'h25, M_ALL);
        sw = 8'h01; idle(1); sb_sample();
        sb_push("to_ready", 4'd3, 8'h01, 8'h25, M_ALL);
        press(3'b001); sb_sample();

        // First decrement exactly 10 cycles after entering TIMER
        sb_push("timer_entry", 4'd2, 8'h01, 8'h25, M_ALL);
        press(3'b010); sb_sample();
        sb_push("timer_pre_tick", 4'd2, 8'h01, 8'h25, M_ALL);
        idle(9); sb_sample();
        sb_push("timer_tick1", 4'd2, 8'h01, 8'h24, M_ALL);
        idle(1); sb_sample();

        // Pause / resume, including a pause coinciding with a tick
        sb_push("pause", 4'd3, 8'h01, 8'h24, M_ALL);
        press(3'b010); sb_sample();
        sb_push("resume", 4'd2, 8'h01, 8'h24, M_ALL);
        press(3'b010); sb_sample();
        idle(5);
        sb_push("pause_on_tick", 4'd3, 8'h01, 8'h24, M_ALL);
        press(3'b010); sb_sample();
        sb_push("paused_hold", 4'd3, 8'h01, 8'h24, M_ALL);
        idle(12); sb_sample();
        sb_push("resume2", 4'd2, 8'h01, 8'h24, M_ALL);
        press(3'b010); sb_sample();
        sb_push("resume2_pre", 4'd2, 8'h01, 8'h24, M_ALL);
        idle(9); sb_sample();
        sb_push("resume2_tick", 4'd2, 8'h01, 8'h23, M_ALL);
        idle(1); sb_sample();

        // CLEAR, then 01:00 -> 00:59 with a SET press ignored in TIMER
        sb_push("clear", 4'd4, 8'h00, 8'h00, M_STATE);
        press(3'b100); sb_sample();
        sw = 8'h00;
        sb_push("clear_zero", 4'd0, 8'h00, 8'h00, M_ALL);
        idle(1); sb_sample();
        sb_push("b_set_min", 4'd1, 8'h00, 8'h00, M_ALL);
        press(3'b001); sb_sample();
        sw = 8'h01;
        sb_push("b_ready", 4'd3, 8'h01, 8'h00, M_ALL);
        press(3'b001); sb_sample();
        sb_push("b_timer", 4'd2, 8'h01, 8'h00, M_ALL);
        press(3'b010); sb_sample();
        sb_push("set_ignored", 4'd2, 8'h01, 8'h00, M_ALL);
        press(3'b001); sb_sample();
        sb_push("borrow_0059", 4'd2, 8'h00, 8'h59, M_ALL);
        idle(5); sb_sample();

        // CLEAR beats START in the same cycle
        sb_push("clr_start", 4'd4, 8'h00, 8'h00, M_STATE);
        press(3'b110); sb_sample();
        sb_push("c_zero", 4'd0, 8'h00, 8'h00, M_ALL);
        idle(1); sb_sample();
        sb_push("c_sec01", 4'd0, 8'h00, 8'h01, M_ALL);
        idle(1); sb_sample();
        sb_push("c_set_min", 4'd1, 8'h00, 8'h01, M_ALL);
        press(3'b001); sb_sample();
        sw = 8'h00;
        sb_push("c_ready", 4'd3, 8'h00, 8'h01, M_ALL);
        press(3'b001); sb_sample();
        sb_push("c_timer", 4'd2, 8'h00, 8'h01, M_ALL);
        press(3'b010); sb_sample();
        sb_push("c_pre_tick", 4'd2, 8'h00, 8'h01, M_ALL);
        idle(9); sb_sample();

        // Final tick goes straight to FLASH_ON, toggling every 4 cycles
        sb_push("flash_on", 4'd5, 8'h00, 8'h00, M_ALL);
        idle(1); sb_sample();
        sb_push("flash_on_hold", 4'd5, 8'h00, 8'h00, M_ALL);
        idle(3); sb_sample();
        sb_push("flash_off", 4'd6, 8'h00, 8'h00, M_ALL);
        idle(1); sb_sample();
        sb_push("flash_off_hold", 4'd6, 8'h00, 8'h00, M_ALL);
        idle(3); sb_sample();
        sb_push("flash_on2", 4'd5, 8'h00, 8'h00, M_ALL);
        idle(1); sb_sample();
        sb_push("flash_start_rst", 4'd4, 8'h00, 8'h00, M_ALL);
        press(3'b010); sb_sample();

        // START with 00:00 in READY
        sb_push("d_set_sec", 4'd0, 8'h00, 8'h00, M_ALL);
        idle(1); sb_sample();
        sb_push("d_set_min", 4'd1, 8'h00, 8'h00, M_ALL);
        press(3'b001); sb_sample();
        sb_push("d_ready", 4'd3, 8'h00, 8'h00, M_ALL);
        press(3'b001); sb_sample();
        sb_push("zero_start", 4'd5, 8'h00, 8'h00, M_ALL);
        press(3'b010); sb_sample();
        sb_push("flash_set_rst", 4'd4, 8'h00, 8'h00, M_ALL);
        press(3'b001); sb_sample();
        sb_push("e_set_sec", 4'd0, 8'h00, 8'h00, M_ALL);
        idle(1); sb_sample();

        // Debounce: one low cycle is ignored, two low cycles are a press
        sb_push("glitch_1cyc", 4'd0, 8'h00, 8'h00, M_ALL);
        @(posedge clk); #1 key = 3'b110;
        @(posedge clk); #1 key = 3'b111;
        idle(6); sb_sample();
        sb_push("press_2cyc", 4'd1, 8'h00, 8'h00, M_ALL);
        @(posedge clk); #1 key = 3'b110;
        @(posedge clk);
        @(posedge clk); #1 key = 3'b111;
        idle(2); sb_sample();

        // Held key gives a single event
        sb_push("no_repeat", 4'd3, 8'h00, 8'h00, M_ALL);
        @(posedge clk); #1 key = 3'b110;
        idle(12);
        key = 3'b111;
        idle(4); sb_sample();

        // Asynchronous reset mid-entry
        sb_push("f_set_sec", 4'd0, 8'h00, 8'h00, M_ALL);
        press(3'b001); sb_sample();
        sb_push("f_sec12", 4'd0, 8'h00, 8'h12, M_ALL);
        sw = 8'h12; idle(1); sb_sample();
        sb_push("async_rst", 4'd4, 8'h00, 8'h00, M_ALL);
        rst_n = 1'b0;
        #2;
        sb_sample();

        check_eq("sb_drain", sb_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
